rr_arbiter_encoder: RTL and testbench
=====================================

RR_ARBITER_ENCODER -- requirements
Module: rr_arbiter_encoder

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum grant length in cycles (used only with TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: request lines; bit k means requester k wants service.
REQ-005 The block SHALL have port done, input, 1 bit: the granted requester releases the grant.
REQ-006 The block SHALL have port grant_idx, output, 2 bits: binary index of the granted requester; drives the 2-to-4 decoder select.
REQ-007 The block SHALL have port grant_en, output, 1 bit: grant active; drives the decoder enable.
REQ-008 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on forced release (tied 0 without TIMEOUT_EN).
REQ-009 All outputs SHALL be registered, with no combinational path from input to output.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req != 0, the block SHALL select the first set bit searching from (last+1) mod 4 upward with wrap. Next cycle: GRANT, grant_idx = selection, grant_en = 1.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with grant_en = 0 and grant_idx holding its previous value.
REQ-013 Grant latency SHALL be one cycle from req sampled in IDLE to grant_en high.
REQ-014 In GRANT, grant_idx SHALL be stable. A release SHALL occur when done = 1, or when req[grant_idx] = 0, at a sampling edge.
REQ-015 On release, the next cycle SHALL be IDLE with grant_en = 0, and last SHALL be set to grant_idx. There SHALL be exactly one idle cycle between consecutive grants.
REQ-016 done and a req[grant_idx] drop in the same cycle SHALL count as a single release.
REQ-017 done while in IDLE SHALL be ignored.
REQ-018 Changes in req bits other than grant_idx during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-019 A requester that holds req continuously SHALL be re-granted only after every other active requester has been served once (strict rotation).
REQ-020 last SHALL be a 2-bit pointer; the wrap from 3 to 0 SHALL be modulo-4.

Reset
REQ-021 With rst = 1 at an edge, the block SHALL go to IDLE and set grant_en = 0, grant_idx = 2'b00, timeout = 0, last = 2'b11 (requester 0 has first priority), and hold counter = 0.
REQ-022 Reset SHALL take priority over all inputs, including mid-grant, where it drops grant_en on the next edge.
REQ-023 The first arbitration after rst deasserts SHALL occur on the following edge.

Configuration
REQ-024 The macro RR_ARBITER_TIMEOUT_EN SHALL control the forced-release feature.
REQ-025 With RR_ARBITER_TIMEOUT_EN defined: a counter SHALL clear on entry to GRANT and increment each GRANT cycle. When it reaches MAX_HOLD-1 without a release, the block SHALL force a release per REQ-015 and set timeout = 1 for that single IDLE cycle.
REQ-026 Without RR_ARBITER_TIMEOUT_EN: no counter SHALL exist, timeout SHALL be constant 0, and a grant SHALL be held indefinitely until done or the request drops.

Verification
REQ-027 rst 1 cycle, then req=4'b0000 for 5 cycles -> grant_en=0, grant_idx=00, timeout=0 throughout.
REQ-028 After reset, req=4'b1111 held, done pulsed 1 cycle at each grant's 3rd cycle -> grant_idx sequence 0,1,2,3,0, each grant 3 cycles long with one grant_en=0 cycle between grants.
REQ-029 last=1, req=4'b0001 -> wrap search grants idx 0. Then req[0] drops to 0 with done=0 -> grant_en=0 on the next cycle.
REQ-030 During grant of idx 2, assert rst -> next edge grant_en=0, grant_idx=00. Then req=4'b0100 -> idx 2 granted one cycle after rst release.
REQ-031 done=1 and req[grant_idx]=0 in the same cycle -> single release, one idle cycle, no double pointer advance (next grant follows rotation from the released index).
REQ-032 With RR_ARBITER_TIMEOUT_EN defined and MAX_HOLD=4, req=4'b0010 held and done=0 -> grant_en high 4 cycles, then timeout=1 with grant_en=0 for 1 cycle, then idx 1 re-granted. Without the macro -> grant_en stays high 20+ cycles and timeout=0.

Source files
------------

// File: rtl/rr_arbiter_encoder.sv
// ---------------------------------------------------------------------------
// rr_arbiter_encoder
//
// Four-requester round-robin arbiter with a binary-encoded grant, intended to
// drive the select/enable of a 2-to-4 decoder. A two-state FSM (IDLE/GRANT)
// arbitrates in IDLE and holds the winner in GRANT until it releases.
// Consecutive grants are always separated by exactly one IDLE cycle.
//
// Optional feature (compile-time macro RR_ARBITER_TIMEOUT_EN):
//   A hold counter forces a release after MAX_HOLD grant cycles and pulses
//   timeout for the following IDLE cycle. Without the macro, no counter
//   exists and timeout is constant 0.
//
// Parameters:
//   MAX_HOLD   maximum grant length in cycles (only used with the timeout)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req[3:0]   request lines, bit k = requester k wants service
//   done       granted requester releases the grant (ignored in IDLE)
//   grant_idx  registered binary index of the granted requester
//   grant_en   registered grant-active flag (decoder enable)
//   timeout    registered one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module rr_arbiter_encoder #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] grant_idx,
    output logic       grant_en,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] idx_q, idx_d;
    logic       en_q, en_d;

    // A hold length below one cycle has no meaning; such a value is left
    // as an empty, clearly named generate branch rather than silently used.
    if (MAX_HOLD < 1) begin : g_max_hold_invalid
    end

    // Round-robin pick: first set request at or after last+1, wrapping mod 4.
    logic [1:0] pick;
    logic       pick_vld;
    logic [1:0] cand;

    always_comb begin
        pick     = 2'b00;
        pick_vld = 1'b0;
        cand     = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cand = last_q + 2'(i + 1);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // done and a dropped request in the same cycle are one release event.
    logic user_rel;
    assign user_rel = done | ~req[idx_q];

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             force_rel;

    // A normal release in the limit cycle wins; timeout flags only forced ones.
    assign force_rel = (cnt_q == CNT_W'(MAX_HOLD - 1)) & ~user_rel;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        en_d    = en_q;
`ifdef RR_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                en_d = 1'b0;
                // grant_idx keeps its previous value while nobody requests.
                if (pick_vld) begin
                    state_d = GRANT;
                    idx_d   = pick;
                    en_d    = 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef RR_ARBITER_TIMEOUT_EN
                if (user_rel || force_rel) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    last_d  = idx_q;
                    to_d    = force_rel;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`else
                if (user_rel) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    last_d  = idx_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // last resets to 3 so that requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'b11;
            idx_q   <= 2'b00;
            en_q    <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign grant_idx = idx_q;
    assign grant_en  = en_q;
`ifdef RR_ARBITER_TIMEOUT_EN
    assign timeout   = to_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_encoder
//
// Self-checking bench for rr_arbiter_encoder. A table of one-cycle vectors
// (inputs applied during a cycle, outputs expected after the following
// rising edge) covers reset, rotation, wrap, mid-grant reset and combined
// release. A hand-written sequence covers the long-hold / timeout behaviour,
// whose expectation depends on RR_ARBITER_TIMEOUT_EN. Expected outputs are
// pushed to a scoreboard queue when stimulus is driven and popped when the
// outputs are sampled, 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] grant_idx;
    logic       grant_en;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arbiter_encoder #(
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .timeout   (timeout)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       en;
        logic [1:0] idx;
        logic       to;
    } vec_t;

    typedef struct {
        logic       en;
        logic [1:0] idx;
        logic       to;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic e_en, input logic [1:0] e_idx, input logic e_to);
        vec_t v;
        v.rst = r; v.req = q; v.done = d;
        v.en = e_en; v.idx = e_idx; v.to = e_to;
        vecs.push_back(v);
    endtask

    task automatic check_one();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (grant_en !== e.en) begin
            n_bad++;
            $display("FAIL %s grant_en: got %b want %b", e.name, grant_en, e.en);
        end
        n_cmp++;
        if (grant_idx !== e.idx) begin
            n_bad++;
            $display("FAIL %s grant_idx: got %0d want %0d", e.name, grant_idx, e.idx);
        end
        n_cmp++;
        if (timeout !== e.to) begin
            n_bad++;
            $display("FAIL %s timeout: got %b want %b", e.name, timeout, e.to);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic d,
                         input logic e_en, input logic [1:0] e_idx, input logic e_to,
                         input string name);
        exp_t e;
        rst  = r;
        req  = q;
        done = d;
        e.en = e_en; e.idx = e_idx; e.to = e_to; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        logic [1:0] order [5];

        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // Reset, then an idle bus for five cycles.
        add(1, 4'b0000, 0, 0, 2'd0, 0);
        repeat (5) add(0, 4'b0000, 0, 0, 2'd0, 0);

        // All four requesting: strict rotation 0,1,2,3,0, three-cycle grants
        // with done in the third cycle and one idle cycle between grants.
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int g = 0; g < 5; g++) begin
            repeat (3) add(0, 4'b1111, 0, 1, order[g], 0);
            add(0, 4'b1111, 1, 0, order[g], 0);
        end

        // Make last = 1, then a lone request 0 must be found by wrapping;
        // dropping it without done releases; done in IDLE is ignored.
        add(0, 4'b0010, 0, 1, 2'd1, 0);
        add(0, 4'b0000, 0, 0, 2'd1, 0);
        add(0, 4'b0001, 0, 1, 2'd0, 0);
        add(0, 4'b0000, 0, 0, 2'd0, 0);
        add(0, 4'b0000, 1, 0, 2'd0, 0);

        // Reset in the middle of a grant to requester 2, then re-grant.
        add(0, 4'b0100, 0, 1, 2'd2, 0);
        add(1, 4'b0100, 0, 0, 2'd0, 0);
        add(0, 4'b0100, 0, 1, 2'd2, 0);
        add(0, 4'b0000, 0, 0, 2'd2, 0);

        // done together with the request drop is one release (last = 3),
        // so the next winner among {0,1} is 0, not 1.
        add(0, 4'b1001, 0, 1, 2'd3, 0);
        add(0, 4'b0001, 1, 0, 2'd3, 0);
        add(0, 4'b0011, 0, 1, 2'd0, 0);
        add(0, 4'b0011, 1, 0, 2'd0, 0);
        add(0, 4'b0011, 0, 1, 2'd1, 0);
        // Other request bits changing mid-grant do not disturb the grant.
        add(0, 4'b1111, 0, 1, 2'd1, 0);
        add(0, 4'b1111, 1, 0, 2'd1, 0);
        add(0, 4'b1111, 0, 1, 2'd2, 0);
        add(0, 4'b0000, 0, 0, 2'd2, 0);

        foreach (vecs[i])
            drive(vecs[i].rst, vecs[i].req, vecs[i].done,
                  vecs[i].en, vecs[i].idx, vecs[i].to, $sformatf("vec%0d", i));

        // Long hold of requester 1 with done never asserted (last = 2 here).
        drive(0, 4'b0010, 0, 1, 2'd1, 0, "hold_c1");
`ifdef RR_ARBITER_TIMEOUT_EN
        for (int c = 2; c <= 4; c++)
            drive(0, 4'b0010, 0, 1, 2'd1, 0, $sformatf("hold_c%0d", c));
        drive(0, 4'b0010, 0, 0, 2'd1, 1, "timeout_idle");
        drive(0, 4'b0010, 0, 1, 2'd1, 0, "regrant_after_timeout");
        drive(0, 4'b0010, 0, 1, 2'd1, 0, "regrant_c2");
`else
        for (int c = 2; c <= 24; c++)
            drive(0, 4'b0010, 0, 1, 2'd1, 0, $sformatf("hold_c%0d", c));
`endif
        drive(0, 4'b0000, 0, 0, 2'd1, 0, "hold_release");

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
